prn_free_list: RTL and testbench

Physical-register free-list manager and structural-hazard controller for the rename stage. It holds every PRN not currently mapped, hands out up to MAX_OPERANDS PRNs per instruction, and accepts up to MAX_OPERANDS PRNs freed by the ROB each cycle. When too few PRNs are free it withholds the grant and raises stall, which freezes fetch/decode and the rename stage.

---
 rtl/foxtrot_rename_pkg.sv | 28 ++
 rtl/prn_free_compact.sv | 41 ++++
 rtl/prn_free_list.sv | 91 +++++++++
 tb/tb_prn_free_list.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/foxtrot_rename_pkg.sv
// Shared rename-stage constants, types and the mod-DEPTH index helper
// used by the physical-register free list.
package foxtrot_rename_pkg;

  localparam int PRN_BITS     = 6;
  localparam int NUM_PRN      = 2 ** PRN_BITS;
  localparam int ARCH_REGS    = 32;
  localparam int MAX_OPERANDS = 3;
  localparam int DEPTH        = NUM_PRN - ARCH_REGS;
  localparam int CNT_BITS     = $clog2(MAX_OPERANDS + 1);
  localparam int IDX_BITS     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_BITS    = $clog2(DEPTH + 1);
  localparam int SUM_BITS     = IDX_BITS + CNT_BITS;

  typedef logic [PRN_BITS-1:0]  prn_t;
  typedef logic [IDX_BITS-1:0]  idx_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;
  typedef logic [FCNT_BITS-1:0] fcnt_t;

  // inc never exceeds MAX_OPERANDS < DEPTH, so one conditional subtract wraps.
  function automatic idx_t wrap_add(idx_t idx, cnt_t inc);
    logic [SUM_BITS-1:0] sum;
    sum = SUM_BITS'(idx) + SUM_BITS'(inc);
    if (sum >= SUM_BITS'(DEPTH)) sum = sum - SUM_BITS'(DEPTH);
    return idx_t'(sum);
  endfunction

endpackage

// File: rtl/prn_free_compact.sv
// Packs the valid free slots into consecutive write lanes (ascending slot
// order) and accepts at most 'limit' of them.
module prn_free_compact
  import foxtrot_rename_pkg::*;
(
  input  logic [MAX_OPERANDS-1:0]          free_valid,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0] free_prns,
  input  logic [CNT_BITS-1:0]              limit,
  output logic [MAX_OPERANDS-1:0]          wr_valid,
  output logic [MAX_OPERANDS*PRN_BITS-1:0] wr_prns,
  output logic [CNT_BITS-1:0]              accepted,
  output logic                             dropped
);

  always_comb begin
    cnt_t rank;
    wr_valid = '0;
    wr_prns  = '0;
    accepted = '0;
    dropped  = 1'b0;
    rank     = '0;
    // rank is the prefix popcount of free_valid below slot i
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      if (free_valid[i]) begin
        if (rank < limit) begin
          for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
            if (rank == cnt_t'(j)) begin
              wr_valid[j]                       = 1'b1;
              wr_prns[j*PRN_BITS +: PRN_BITS]   = free_prns[i*PRN_BITS +: PRN_BITS];
            end
          end
          accepted = accepted + cnt_t'(1);
        end else begin
          dropped = 1'b1;
        end
        rank = rank + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/prn_free_list.sv
// Physical-register free list: circular buffer of unmapped PRNs with
// combinational multi-PRN grant and per-cycle ROB frees.
module prn_free_list
  import foxtrot_rename_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req,
  input  logic [CNT_BITS-1:0]              alloc_count,
  output logic                             alloc_grant,
  output logic                             stall,
  output logic [MAX_OPERANDS-1:0]          alloc_valid,
  output logic [MAX_OPERANDS*PRN_BITS-1:0] alloc_prn,
  input  logic [MAX_OPERANDS-1:0]          free_valid,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0] free_prns,
  output logic [FCNT_BITS-1:0]             free_count,
  output logic                             overflow_err,
  output logic                             bad_req_err
);

  prn_t  fl_buf [DEPTH];
  idx_t  head;
  idx_t  tail;
  fcnt_t count;

  logic                             bad_req;
  logic [CNT_BITS:0]                req_ext;
  cnt_t                             granted;
  fcnt_t                            after_alloc;
  fcnt_t                            room;
  cnt_t                             limit;
  logic [MAX_OPERANDS-1:0]          wr_valid;
  logic [MAX_OPERANDS*PRN_BITS-1:0] wr_prns;
  cnt_t                             accepted;
  logic                             dropped;

  assign free_count = count;

  always_comb begin
    req_ext     = {1'b0, alloc_count};
    bad_req     = alloc_req && (req_ext > (CNT_BITS+1)'(MAX_OPERANDS));
    alloc_grant = !rst && alloc_req && !bad_req && (fcnt_t'(alloc_count) <= count);
    stall       = !rst && alloc_req && !alloc_grant;
    alloc_valid = '0;
    alloc_prn   = '0;
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      alloc_valid[i]                   = alloc_grant && (cnt_t'(i) < alloc_count);
      alloc_prn[i*PRN_BITS +: PRN_BITS] = fl_buf[wrap_add(head, cnt_t'(i))];
    end
    granted     = alloc_grant ? alloc_count : '0;
    after_alloc = count - fcnt_t'(granted);
    // same-cycle frees only fill space left after this cycle's allocation
    room        = fcnt_t'(DEPTH) - after_alloc;
    limit       = (room > fcnt_t'(MAX_OPERANDS)) ? cnt_t'(MAX_OPERANDS) : cnt_t'(room);
  end

  prn_free_compact u_compact (
    .free_valid (free_valid),
    .free_prns  (free_prns),
    .limit      (limit),
    .wr_valid   (wr_valid),
    .wr_prns    (wr_prns),
    .accepted   (accepted),
    .dropped    (dropped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fl_buf[i] <= prn_t'(ARCH_REGS + i);
      end
      head         <= '0;
      tail         <= '0;
      count        <= fcnt_t'(DEPTH);
      overflow_err <= 1'b0;
      bad_req_err  <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
        if (wr_valid[j]) begin
          fl_buf[wrap_add(tail, cnt_t'(j))] <= wr_prns[j*PRN_BITS +: PRN_BITS];
        end
      end
      if (alloc_grant) head <= wrap_add(head, alloc_count);
      tail         <= wrap_add(tail, accepted);
      count        <= after_alloc + fcnt_t'(accepted);
      overflow_err <= overflow_err | dropped;
      bad_req_err  <= bad_req_err | bad_req;
    end
  end

endmodule

// File: tb/tb_prn_free_list.sv
// Self-checking bench for prn_free_list: directed scenarios plus randomized
// traffic against a queue-based free-list model.
module tb_prn_free_list;
  import foxtrot_rename_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             alloc_req = 1'b0;
  logic [CNT_BITS-1:0]              alloc_count = '0;
  logic                             alloc_grant;
  logic                             stall;
  logic [MAX_OPERANDS-1:0]          alloc_valid;
  logic [MAX_OPERANDS*PRN_BITS-1:0] alloc_prn;
  logic [MAX_OPERANDS-1:0]          free_valid = '0;
  logic [MAX_OPERANDS*PRN_BITS-1:0] free_prns = '0;
  logic [FCNT_BITS-1:0]             free_count;
  logic                             overflow_err;
  logic                             bad_req_err;

  prn_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_count  (alloc_count),
    .alloc_grant  (alloc_grant),
    .stall        (stall),
    .alloc_valid  (alloc_valid),
    .alloc_prn    (alloc_prn),
    .free_valid   (free_valid),
    .free_prns    (free_prns),
    .free_count   (free_count),
    .overflow_err (overflow_err),
    .bad_req_err  (bad_req_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: list of free PRNs in issue order.
  int fl[$];
  bit m_ovf;
  int outstanding[$];

  task automatic model_reset();
    fl.delete();
    outstanding.delete();
    for (int i = 0; i < DEPTH; i++) fl.push_back(ARCH_REGS + i);
    m_ovf = 0;
  endtask

  function automatic bit exp_grant();
    return alloc_req && (int'(alloc_count) <= MAX_OPERANDS) && (int'(alloc_count) <= fl.size());
  endfunction

  function automatic int prn_slot(int i);
    return int'(alloc_prn[i*PRN_BITS +: PRN_BITS]);
  endfunction

  function automatic logic [MAX_OPERANDS*PRN_BITS-1:0] pack3(int p0, int p1, int p2);
    return {PRN_BITS'(p2), PRN_BITS'(p1), PRN_BITS'(p0)};
  endfunction

  task automatic model_edge();
    if (exp_grant()) begin
      for (int i = 0; i < int'(alloc_count); i++) outstanding.push_back(fl.pop_front());
    end
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (free_valid[i]) begin
        if (fl.size() < DEPTH) fl.push_back(int'(free_prns[i*PRN_BITS +: PRN_BITS]));
        else m_ovf = 1;
      end
    end
  endtask

  task automatic drive(bit req, int cnt, logic [MAX_OPERANDS-1:0] fv, logic [MAX_OPERANDS*PRN_BITS-1:0] fp);
    alloc_req   = req;
    alloc_count = cnt[CNT_BITS-1:0];
    free_valid  = fv;
    free_prns   = fp;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 3, '0, '0);
    checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", alloc_grant); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (alloc_valid !== 3'b000) begin errors++; $display("FAIL rst_valid got %b want 000", alloc_valid); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL rst_count got %0d want 32", free_count); end
    checks++; if ({overflow_err, bad_req_err} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b want 00", {overflow_err, bad_req_err}); end
  endtask

  task automatic test_alloc_basic();
    drive(1, 3, '0, '0);
    checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL basic_grant got %b want 1", alloc_grant); end
    checks++; if (alloc_valid !== 3'b111) begin errors++; $display("FAIL basic_valid got %b want 111", alloc_valid); end
    checks++; if (prn_slot(0) != 32 || prn_slot(1) != 33 || prn_slot(2) != 34) begin
      errors++; $display("FAIL basic_prn got %0d,%0d,%0d want 32,33,34", prn_slot(0), prn_slot(1), prn_slot(2)); end
    tick();
    drive(0, 0, '0, '0);
    checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL basic_count got %0d want 29", free_count); end
  endtask

  task automatic test_exhaust();
    for (int k = 0; k < 9; k++) begin
      drive(1, 3, '0, '0);
      checks++; if (alloc_grant !== 1'b1 || prn_slot(0) != 35 + 3*k) begin
        errors++; $display("FAIL exh_grant k=%0d got g=%b prn=%0d want g=1 prn=%0d", k, alloc_grant, prn_slot(0), 35 + 3*k); end
      tick();
    end
    drive(1, 3, '0, '0);
    checks++; if (free_count !== 6'd2) begin errors++; $display("FAIL exh_count got %0d want 2", free_count); end
    checks++; if (alloc_grant !== 1'b0 || stall !== 1'b1 || alloc_valid !== 3'b000) begin
      errors++; $display("FAIL exh_stall got g=%b s=%b v=%b want g=0 s=1 v=000", alloc_grant, stall, alloc_valid); end
    tick();
    drive(1, 2, '0, '0);
    checks++; if (free_count !== 6'd2) begin errors++; $display("FAIL exh_hold got %0d want 2", free_count); end
    checks++; if (alloc_grant !== 1'b1 || alloc_valid !== 3'b011 || prn_slot(0) != 62 || prn_slot(1) != 63) begin
      errors++; $display("FAIL exh_last got g=%b v=%b prn=%0d,%0d want g=1 v=011 prn=62,63", alloc_grant, alloc_valid, prn_slot(0), prn_slot(1)); end
    tick();
    drive(0, 0, '0, '0);
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL exh_empty got %0d want 0", free_count); end
  endtask

  task automatic test_free_wrap();
    drive(0, 0, 3'b110, pack3($urandom_range(0, 63), 5, 9));
    tick();
    drive(1, 2, '0, '0);
    checks++; if (free_count !== 6'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", free_count); end
    checks++; if (alloc_grant !== 1'b1 || prn_slot(0) != 5 || prn_slot(1) != 9) begin
      errors++; $display("FAIL wrap_prn got g=%b prn=%0d,%0d want g=1 prn=5,9", alloc_grant, prn_slot(0), prn_slot(1)); end
    tick();
  endtask

  task automatic test_no_bypass();
    drive(0, 0, 3'b001, pack3(7, 0, 0));
    tick();
    drive(1, 2, 3'b101, pack3(11, 0, 13));
    checks++; if (alloc_grant !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL nobyp_stall got g=%b s=%b want g=0 s=1", alloc_grant, stall); end
    tick();
    drive(1, 2, '0, '0);
    checks++; if (free_count !== 6'd3) begin errors++; $display("FAIL nobyp_count got %0d want 3", free_count); end
    checks++; if (alloc_grant !== 1'b1 || prn_slot(0) != 7 || prn_slot(1) != 11) begin
      errors++; $display("FAIL nobyp_grant got g=%b prn=%0d,%0d want g=1 prn=7,11", alloc_grant, prn_slot(0), prn_slot(1)); end
    tick();
  endtask

  task automatic test_overflow();
    drive(0, 0, '0, '0);
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    drive(0, 0, 3'b010, pack3(0, 40, 0));
    tick();
    drive(1, 1, '0, '0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d want 32", free_count); end
    checks++; if (alloc_grant !== 1'b1 || prn_slot(0) != 32) begin
      errors++; $display("FAIL ovf_next got g=%b prn=%0d want g=1 prn=32", alloc_grant, prn_slot(0)); end
    tick();
    drive(0, 0, '0, '0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [MAX_OPERANDS-1:0]          fv;
      logic [MAX_OPERANDS*PRN_BITS-1:0] fp;
      bit req;
      int cnt;
      bit eg;
      req = ($urandom_range(0, 9) < 7);
      cnt = $urandom_range(0, MAX_OPERANDS);
      fv  = MAX_OPERANDS'($urandom);
      fp  = '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        int p;
        if (fv[i] && outstanding.size() > 0 && $urandom_range(0, 15) != 0) begin
          int k;
          k = $urandom_range(0, outstanding.size() - 1);
          p = outstanding[k];
          outstanding.delete(k);
        end else begin
          p = $urandom_range(ARCH_REGS, NUM_PRN - 1);
        end
        fp[i*PRN_BITS +: PRN_BITS] = PRN_BITS'(p);
      end
      drive(req, cnt, fv, fp);
      eg = exp_grant();
      checks++; if (alloc_grant !== eg || stall !== (req && !eg)) begin
        errors++; $display("FAIL rnd_grant cyc=%0d got g=%b s=%b want g=%b s=%b", cyc, alloc_grant, stall, eg, req && !eg); end
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        bit ev;
        ev = eg && (i < cnt);
        checks++; if (alloc_valid[i] !== ev) begin
          errors++; $display("FAIL rnd_valid cyc=%0d slot=%0d got %b want %b", cyc, i, alloc_valid[i], ev); end
        if (i < fl.size()) begin
          checks++; if (prn_slot(i) != fl[i]) begin
            errors++; $display("FAIL rnd_prn cyc=%0d slot=%0d got %0d want %0d", cyc, i, prn_slot(i), fl[i]); end
        end
      end
      checks++; if (int'(free_count) != fl.size()) begin
        errors++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", cyc, free_count, fl.size()); end
      checks++; if (overflow_err !== m_ovf || bad_req_err !== 1'b0) begin
        errors++; $display("FAIL rnd_errs cyc=%0d got ovf=%b bad=%b want ovf=%b bad=0", cyc, overflow_err, bad_req_err, m_ovf); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1, 2, 3'b001, pack3(50, 0, 0));
    #2 rst = 1'b1;
    #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL arst_count got %0d want 32", free_count); end
    checks++; if (alloc_grant !== 1'b0 || stall !== 1'b0 || alloc_valid !== 3'b000) begin
      errors++; $display("FAIL arst_outs got g=%b s=%b v=%b want 0,0,000", alloc_grant, stall, alloc_valid); end
    checks++; if ({overflow_err, bad_req_err} !== 2'b00) begin
      errors++; $display("FAIL arst_errs got %b want 00", {overflow_err, bad_req_err}); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 3, '0, '0);
    checks++; if (alloc_grant !== 1'b1 || prn_slot(0) != 32 || prn_slot(1) != 33 || prn_slot(2) != 34) begin
      errors++; $display("FAIL arst_first got g=%b prn=%0d,%0d,%0d want g=1 prn=32,33,34", alloc_grant, prn_slot(0), prn_slot(1), prn_slot(2)); end
    tick();
    drive(0, 0, '0, '0);
    checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL arst_after got %0d want 29", free_count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alloc_basic();
    test_exhaust();
    test_free_wrap();
    test_no_bypass();
    test_overflow();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
